// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with packet-locked arbitration
// (external select, fixed priority or round-robin) and a registered output stage.
module stream_mux_arb #(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter int MODE = 2,
  localparam int SW = $clog2(N_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [N_CH*W-1:0] d_in,
  input  logic [N_CH-1:0]   valid_in,
  input  logic [N_CH-1:0]   last_in,
  output logic [N_CH-1:0]   ready_out,
  input  logic [SW-1:0]     sel_in,
  output logic [W-1:0]      y_out,
  output logic              y_last_out,
  output logic [SW-1:0]     y_ch_out,
  output logic              y_valid_out,
  input  logic              y_ready_in
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] lock_ch, rr_ptr, g;
  logic          grant_valid, load, accept, g_valid, g_last;
  logic [W-1:0]  g_data;
  int            idx;

  assign load   = !y_valid_out || y_ready_in;
  assign accept = load && grant_valid && g_valid;

  // While locked the grant is frozen; otherwise it is chosen afresh per MODE
  always_comb begin
    g = '0;
    grant_valid = 1'b0;
    idx = 0;
    if (state == LOCKED) begin
      g = lock_ch;
      grant_valid = 1'b1;
    end else if (MODE == 0) begin
      g = sel_in;
      grant_valid = (int'(sel_in) < N_CH);
    end else if (MODE == 1) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (valid_in[i]) begin
          g = SW'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (valid_in[idx]) begin
          g = SW'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (g == SW'(i)) begin
        g_valid = valid_in[i];
        g_last  = last_in[i];
        g_data  = d_in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !g_last) state_nxt = LOCKED;
      LOCKED:  if (accept && g_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is masked during reset so no producer sees a handshake it cannot complete
  always_comb begin
    ready_out = '0;
    for (int i = 0; i < N_CH; i++)
      ready_out[i] = rst_n_in && load && grant_valid && (g == SW'(i));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out       <= '0;
      y_last_out  <= 1'b0;
      y_ch_out    <= '0;
      y_valid_out <= 1'b0;
      lock_ch     <= '0;
      rr_ptr      <= '0;
    end else begin
      if (accept) begin
        y_out       <= g_data;
        y_last_out  <= g_last;
        y_ch_out    <= g;
        y_valid_out <= 1'b1;
      end else if (load) begin
        y_valid_out <= 1'b0;
      end
      if (accept && state == IDLE) lock_ch <= g;
      if (accept && g_last) rr_ptr <= (g == SW'(N_CH - 1)) ? '0 : g + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: one instance per arbitration mode plus a
// 3-channel external-select instance for the out-of-range select case.
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_in = '0;
  logic [3:0]  valid_in = '0;
  logic [3:0]  last_in = '0;
  logic [1:0]  sel_in = '0;
  logic        y_ready = 1'b0;

  logic [3:0] rdy0, rdy1, rdy2;
  logic [7:0] y0, y1, y2, y3;
  logic       yl0, yl1, yl2, yl3, yv0, yv1, yv2, yv3;
  logic [1:0] yc0, yc1, yc2, yc3;
  logic [2:0] rdy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_arb #(.N_CH(4), .W(8), .MODE(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(rdy0), .sel_in(sel_in), .y_out(y0), .y_last_out(yl0), .y_ch_out(yc0),
    .y_valid_out(yv0), .y_ready_in(y_ready));

  stream_mux_arb #(.N_CH(4), .W(8), .MODE(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(rdy1), .sel_in(sel_in), .y_out(y1), .y_last_out(yl1), .y_ch_out(yc1),
    .y_valid_out(yv1), .y_ready_in(y_ready));

  stream_mux_arb #(.N_CH(4), .W(8), .MODE(2)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(rdy2), .sel_in(sel_in), .y_out(y2), .y_last_out(yl2), .y_ch_out(yc2),
    .y_valid_out(yv2), .y_ready_in(y_ready));

  stream_mux_arb #(.N_CH(3), .W(8), .MODE(0)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d_in[23:0]), .valid_in(valid_in[2:0]),
    .last_in(last_in[2:0]), .ready_out(rdy3), .sel_in(sel_in), .y_out(y3),
    .y_last_out(yl3), .y_ch_out(yc3), .y_valid_out(yv3), .y_ready_in(y_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    d_in[ch*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = '0;
    last_in = '0;
    d_in = '0;
    sel_in = '0;
    y_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 4'b1111;
    y_ready = 1'b1;
    #3;
    checks++; if (yv1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", yv1); end
    checks++; if (y1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_y got %h want 00", y1); end
    checks++; if (yc2 !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch got %0d want 0", yc2); end
    checks++; if (yl2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", yl2); end
    checks++; if (rdy1 !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b want 0000", rdy1); end
    do_reset();
  endtask

  task automatic test_ext_select();
    do_reset();
    sel_in = 2'd2;
    set_ch(2, 8'hA5);
    valid_in = 4'b0100;
    last_in = 4'b0100;
    #1;
    checks++; if (rdy0 !== 4'b0100) begin errors++; $display("[TB] FAIL m0_ready got %b want 0100", rdy0); end
    step();
    valid_in = '0;
    checks++; if (yv0 !== 1'b1) begin errors++; $display("[TB] FAIL m0_valid got %b want 1", yv0); end
    checks++; if (y0 !== 8'hA5) begin errors++; $display("[TB] FAIL m0_data got %h want a5", y0); end
    checks++; if (yc0 !== 2'd2) begin errors++; $display("[TB] FAIL m0_ch got %0d want 2", yc0); end
    checks++; if (yl0 !== 1'b1) begin errors++; $display("[TB] FAIL m0_last got %b want 1", yl0); end
    step();
    checks++; if (yv0 !== 1'b0) begin errors++; $display("[TB] FAIL m0_drain got %b want 0", yv0); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 8'h10 + 8'(i));
    valid_in = 4'b1111;
    last_in = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++; if (yc2 !== exp_ch[n]) begin errors++; $display("[TB] FAIL rr_ch[%0d] got %0d want %0d", n, yc2, exp_ch[n]); end
      checks++; if (y2 !== 8'h10 + 8'(exp_ch[n])) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h want %h", n, y2, 8'h10 + 8'(exp_ch[n])); end
    end
    valid_in = '0;
    step();
  endtask

  task automatic test_priority_lock();
    logic [7:0] exp_d [3] = '{8'h31, 8'h32, 8'h33};
    do_reset();
    for (int b = 0; b < 3; b++) begin
      set_ch(1, exp_d[b]);
      set_ch(0, 8'h0C);
      last_in = (b == 2) ? 4'b0011 : 4'b0001;
      valid_in = (b == 0) ? 4'b0010 : 4'b0011;
      #1;
      checks++; if (rdy1 !== 4'b0010) begin errors++; $display("[TB] FAIL prio_ready[%0d] got %b want 0010", b, rdy1); end
      step();
      checks++; if (y1 !== exp_d[b] || yc1 !== 2'd1) begin errors++; $display("[TB] FAIL prio_beat[%0d] got %h/ch%0d want %h/ch1", b, y1, yc1, exp_d[b]); end
    end
    checks++; if (yl1 !== 1'b1) begin errors++; $display("[TB] FAIL prio_last got %b want 1", yl1); end
    set_ch(1, 8'h34);
    valid_in = 4'b0011;
    last_in = 4'b0011;
    step();
    checks++; if (y1 !== 8'h0C || yc1 !== 2'd0) begin errors++; $display("[TB] FAIL prio_ch0 got %h/ch%0d want 0c/ch0", y1, yc1); end
    valid_in = '0;
    step();
  endtask

  task automatic test_back_pressure();
    do_reset();
    y_ready = 1'b0;
    set_ch(3, 8'h71);
    valid_in = 4'b1000;
    last_in = 4'b1000;
    #1;
    checks++; if (rdy2 !== 4'b1000) begin errors++; $display("[TB] FAIL bp_first_ready got %b want 1000", rdy2); end
    step();
    set_ch(3, 8'h72);
    for (int c = 0; c < 5; c++) begin
      checks++; if (rdy2 !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b want 0000", c, rdy2); end
      checks++; if (y2 !== 8'h71 || yv2 !== 1'b1 || yc2 !== 2'd3) begin errors++; $display("[TB] FAIL bp_hold[%0d] got %h v%b ch%0d want 71 v1 ch3", c, y2, yv2, yc2); end
      step();
    end
    y_ready = 1'b1;
    #1;
    checks++; if (rdy2 !== 4'b1000) begin errors++; $display("[TB] FAIL bp_resume_ready got %b want 1000", rdy2); end
    step();
    valid_in = '0;
    checks++; if (y2 !== 8'h72 || yv2 !== 1'b1) begin errors++; $display("[TB] FAIL bp_second got %h v%b want 72 v1", y2, yv2); end
    step();
    checks++; if (yv2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b want 0", yv2); end
  endtask

  task automatic test_select_switch();
    do_reset();
    sel_in = 2'd1;
    set_ch(1, 8'h41);
    set_ch(3, 8'h81);
    valid_in = 4'b1010;
    last_in = 4'b1000;
    step();
    checks++; if (y0 !== 8'h41 || yc0 !== 2'd1) begin errors++; $display("[TB] FAIL sw_beat1 got %h/ch%0d want 41/ch1", y0, yc0); end
    sel_in = 2'd3;
    set_ch(1, 8'h42);
    last_in = 4'b1010;
    #1;
    checks++; if (rdy0 !== 4'b0010) begin errors++; $display("[TB] FAIL sw_locked_ready got %b want 0010", rdy0); end
    step();
    checks++; if (y0 !== 8'h42 || yc0 !== 2'd1 || yl0 !== 1'b1) begin errors++; $display("[TB] FAIL sw_beat2 got %h/ch%0d/l%b want 42/ch1/l1", y0, yc0, yl0); end
    valid_in = 4'b1000;
    step();
    checks++; if (y0 !== 8'h81 || yc0 !== 2'd3) begin errors++; $display("[TB] FAIL sw_ch3 got %h/ch%0d want 81/ch3", y0, yc0); end
    valid_in = '0;
    step();
    sel_in = 2'd3;
    valid_in = 4'b0111;
    last_in = 4'b0111;
    #1;
    checks++; if (rdy3 !== 3'b000) begin errors++; $display("[TB] FAIL sel_range_ready got %b want 000", rdy3); end
    step();
    checks++; if (yv3 !== 1'b0) begin errors++; $display("[TB] FAIL sel_range_valid got %b want 0", yv3); end
    valid_in = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_ch(2, 8'h52);
    valid_in = 4'b0100;
    last_in = 4'b0000;
    step();
    checks++; if (y2 !== 8'h52 || yc2 !== 2'd2) begin errors++; $display("[TB] FAIL mid_beat got %h/ch%0d want 52/ch2", y2, yc2); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (yv2 !== 1'b0 || y2 !== 8'h00 || yc2 !== 2'd0 || rdy2 !== 4'b0000) begin
      errors++; $display("[TB] FAIL mid_async got v%b %h ch%0d r%b want v0 00 ch0 r0000", yv2, y2, yc2, rdy2);
    end
    for (int i = 0; i < 4; i++) set_ch(i, 8'h60 + 8'(i));
    valid_in = 4'b1111;
    last_in = 4'b1111;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (yc2 !== 2'd0 || y2 !== 8'h60) begin errors++; $display("[TB] FAIL mid_regrant got %h/ch%0d want 60/ch0", y2, yc2); end
    valid_in = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_ext_select();
    test_round_robin();
    test_priority_lock();
    test_back_pressure();
    test_select_switch();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
